// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
// The receiver and the transmitter both use this package.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int uart_cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int uart_count_width(input int cycles_per_bit);
        return 1 + $clog2(cycles_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus history taps.
// With UART_RX_MAJORITY_EN defined, sample_o is a 2-of-3 vote over the last three rxd_s values.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic rxd_p_o,
    output logic sample_o
);

    logic meta_q;
    logic rxd_s_q;
    logic rxd_p_q;

    // Synchronizer chain and one-cycle history; idle line level is 1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q  <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_p_q <= 1'b1;
        end else begin
            meta_q  <= rxd_i;
            rxd_s_q <= meta_q;
            rxd_p_q <= rxd_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxd_h_q;

    // Extra history flop feeding the majority vote
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_h_q <= 1'b1;
        end else begin
            rxd_h_q <= rxd_p_q;
        end
    end

    assign sample_o = (rxd_s_q & rxd_p_q) | (rxd_s_q & rxd_h_q) | (rxd_p_q & rxd_h_q);
`else
    assign sample_o = rxd_s_q;
`endif

    assign rxd_s_o = rxd_s_q;
    assign rxd_p_o = rxd_p_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, PAYLOAD_BITS LSB-first data, STOP_BITS stop, no parity.
// Optional UART_RX_MAJORITY_EN switches every sample point to a 3-tap majority vote.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int CYCLES_PER_BIT = uart_cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW             = uart_count_width(CYCLES_PER_BIT);

    localparam logic [CW-1:0]           CNT_HALF  = CW'(CYCLES_PER_BIT / 2);
    localparam logic [CW-1:0]           CNT_BIT   = CW'(CYCLES_PER_BIT);
    localparam logic [CW-1:0]           CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]           CNT_ZERO  = CW'(0);
    localparam logic [3:0]              LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]              LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [PAYLOAD_BITS-1:0] WORD_ZERO = {PAYLOAD_BITS{1'b0}};

    logic rxd_s;
    logic rxd_p;
    logic sample_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .rxd_i    (uart_rxd),
        .rxd_s_o  (rxd_s),
        .rxd_p_o  (rxd_p),
        .sample_o (sample_s)
    );

    uart_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic                    stop_low_q, stop_low_d;
    logic                    stop_high_q, stop_high_d;
    logic                    valid_q, valid_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;
    logic                    any_low_s;
    logic                    any_high_s;

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            bit_q       <= 4'd0;
            shreg_q     <= WORD_ZERO;
            stop_low_q  <= 1'b0;
            stop_high_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= WORD_ZERO;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            stop_low_q  <= stop_low_d;
            stop_high_q <= stop_high_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
        end
    end

    // Next-state and output decode; status outputs are single-cycle pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        stop_low_d  = stop_low_q;
        stop_high_d = stop_high_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        ferr_d      = 1'b0;
        brk_d       = 1'b0;
        any_low_s   = stop_low_q | ~sample_s;
        any_high_s  = stop_high_q | sample_s;

        case (state_q)
            IDLE: begin
                cnt_d       = CNT_ZERO;
                bit_d       = 4'd0;
                stop_low_d  = 1'b0;
                stop_high_d = 1'b0;
                // Edge-triggered so a line held low (break) never re-arms
                if (uart_rx_en && rxd_p && !rxd_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    if (sample_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RECV: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d                   = CNT_ZERO;
                    shreg_d                 = shreg_q >> 1;
                    shreg_d[PAYLOAD_BITS-1] = sample_s;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 4'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d       = CNT_ZERO;
                    stop_low_d  = any_low_s;
                    stop_high_d = any_high_s;
                    if (bit_q == LAST_STOP) begin
                        bit_d   = 4'd0;
                        state_d = IDLE;
                        if (!any_low_s) begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                        end else begin
                            ferr_d = 1'b1;
                            brk_d  = !any_high_s && (shreg_q == WORD_ZERO);
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_data      = data_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_break     = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: expected events are queued when a frame is driven
// and compared (kind, data, exact cycle) when the receiver reports.
module tb_uart_rx;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BIT_RATE  = 100_000;
    localparam int PB        = 8;
    localparam int SB        = 1;
    localparam int P         = 11;
    localparam int FRAME_CYC = (1 + PB + SB) * P;
    localparam int LAT       = 108;   // pin start cycle to report cycle (2 sync + 106)

    typedef struct {
        logic       err;
        logic       brk;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       sb_q[$];
    logic [7:0] model_last = 8'h00;

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (PB),
        .STOP_BITS    (SB)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic bit_at(input logic [7:0] d, input logic stop_v, input int i);
        int idx;
        idx = i / P;
        if (idx == 0) return 1'b0;
        if (idx <= PB) return d[idx-1];
        return stop_v;
    endfunction

    task automatic idle_line(input int n);
        uart_rxd = 1'b1;
        tick(n);
    endtask

    // Drive one frame; optionally invert one cycle and/or drop enable at a given offset.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] exp_d, input logic stop_v,
                              input int glitch_at, input int drop_en_at, input logic push);
        exp_t e;
        logic v;
        if (push) begin
            e.err  = ~stop_v;
            e.brk  = ~stop_v && (d == 8'h00);
            e.data = stop_v ? exp_d : model_last;
            e.cyc  = cyc + LAT;
            sb_q.push_back(e);
            if (stop_v) model_last = exp_d;
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            v = bit_at(d, stop_v, i);
            if (i == glitch_at) v = ~v;
            if (i == drop_en_at) uart_rx_en = 1'b0;
            uart_rxd = v;
            tick(1);
        end
    endtask

    // Scoreboard consumer, sampled mid-cycle
    always @(negedge clk) begin
        if (resetn && (uart_rx_valid || uart_rx_frame_err || uart_rx_break)) begin
            exp_t e;
            check_eq("mutex", {31'd0, uart_rx_valid & uart_rx_frame_err}, 32'd0);
            check_eq("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("valid",     {31'd0, uart_rx_valid},     {31'd0, ~e.err});
                check_eq("frame_err", {31'd0, uart_rx_frame_err}, {31'd0, e.err});
                check_eq("break",     {31'd0, uart_rx_break},     {31'd0, e.brk});
                check_eq("data",      {24'd0, uart_rx_data},      {24'd0, e.data});
                check_eq("cycle",     cyc,                        e.cyc);
            end
        end
    end

    initial begin
        resetn     = 1'b0;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        tick(3);
        check_eq("rst_valid", {31'd0, uart_rx_valid},     32'd0);
        check_eq("rst_data",  {24'd0, uart_rx_data},      32'd0);
        check_eq("rst_ferr",  {31'd0, uart_rx_frame_err}, 32'd0);
        check_eq("rst_brk",   {31'd0, uart_rx_break},     32'd0);
        check_eq("rst_state", {30'd0, dut.state_q},       32'd0);
        resetn = 1'b1;
        idle_line(5);

        // Good frame
        send_frame(8'hA5, 8'hA5, 1'b1, -1, -1, 1'b1);
        idle_line(2 * P);

        // Start glitch: 3 low cycles, then a real frame
        uart_rxd = 1'b0;
        tick(3);
        idle_line(3 * P);
        check_eq("glitch_idle", {30'd0, dut.state_q}, 32'd0);
        send_frame(8'h3C, 8'h3C, 1'b1, -1, -1, 1'b1);
        idle_line(2 * P);

        // Framing error, break, recovery
        send_frame(8'h55, 8'h00, 1'b0, -1, -1, 1'b1);
        idle_line(2 * P);
        begin
            exp_t e;
            e.err = 1'b1; e.brk = 1'b1; e.data = model_last; e.cyc = cyc + LAT;
            sb_q.push_back(e);
        end
        uart_rxd = 1'b0;
        tick(15 * P);
        check_eq("break_no_retrigger", {30'd0, dut.state_q}, 32'd0);
        idle_line(2 * P);
        send_frame(8'h01, 8'h01, 1'b1, -1, -1, 1'b1);
        idle_line(2 * P);

        // Reset in the middle of data bit 4
        for (int i = 0; i < 5 * P + 5; i++) begin
            uart_rxd = bit_at(8'hFF, 1'b1, i);
            tick(1);
        end
        resetn = 1'b0;
        #1;
        check_eq("mrst_valid", {31'd0, uart_rx_valid},     32'd0);
        check_eq("mrst_data",  {24'd0, uart_rx_data},      32'd0);
        check_eq("mrst_ferr",  {31'd0, uart_rx_frame_err}, 32'd0);
        check_eq("mrst_state", {30'd0, dut.state_q},       32'd0);
        model_last = 8'h00;
        uart_rxd   = 1'b1;
        tick(3);
        resetn = 1'b1;
        idle_line(2 * P);
        send_frame(8'hFF, 8'hFF, 1'b1, -1, -1, 1'b1);
        idle_line(2 * P);

        // Back-to-back frames; enable dropped mid-second frame; third frame ignored
        send_frame(8'h12, 8'h12, 1'b1, -1, -1, 1'b1);
        send_frame(8'h34, 8'h34, 1'b1, -1, 5 * P, 1'b1);
        send_frame(8'hC3, 8'h00, 1'b1, -1, -1, 1'b0);
        idle_line(2 * P);
        uart_rx_en = 1'b1;
        idle_line(P);

        // One-cycle high glitch on the bit-2 sample cycle of a 0x00 frame
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 8'h00, 1'b1, 3 * P + 6, -1, 1'b1);
`else
        send_frame(8'h00, 8'h04, 1'b1, 3 * P + 6, -1, 1'b1);
`endif
        idle_line(4 * P);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers bytes from the asynchronous serial line `uart_rxd` and presents each good word as a one-cycle `uart_rx_valid` pulse. It is the receive-side companion of the team's UART transmitter and uses the same frame format and bit timing: 1 start bit, `PAYLOAD_BITS` LSB-first data bits, `STOP_BITS` stop bits, no parity. It sits between the board RX pin and the byte-level command logic.

## Interface
- `BIT_RATE`, 9600, line bit rate in bits/s.
- `CLK_HZ`, 50_000_000, `clk` frequency in Hz.
- `PAYLOAD_BITS`, 8, data bits per frame (1..8).
- `STOP_BITS`, 1, stop bits per frame (1..2).
- Derived values:
  - `CYCLES_PER_BIT = CLK_HZ/BIT_RATE` (integer division).
  - Bit period `P = CYCLES_PER_BIT+1` clocks.
  - `HALF = CYCLES_PER_BIT/2`.
  - Counter width `1+$clog2(CYCLES_PER_BIT)`.
- `clk` in 1 system clock. Everything is synchronous to its rising edge.
- `resetn` in 1 asynchronous active-low reset.
- `uart_rxd` in 1 raw serial line, asynchronous to `clk`.
- `uart_rx_en` in 1 enables detection of new start bits.
- `uart_rx_valid` out 1 one-cycle pulse: `uart_rx_data` holds a new good word.
- `uart_rx_data` out `PAYLOAD_BITS` last good word received.
- `uart_rx_frame_err` out 1 one-cycle pulse: a stop bit was sampled low.
- `uart_rx_break` out 1 one-cycle pulse, coincident with `uart_rx_frame_err`: every data bit and every stop bit sampled 0.

## Operation
- **Reset values.**
  - Synchronizer flops: 1.
  - All outputs: 0.
  - FSM: IDLE.
  - All counters: 0.
- **Synchronizer.** `uart_rxd` passes through 2 flops to give `rxd_s`. A third flop, `rxd_p`, holds the previous `rxd_s`.
- **FSM states and transitions.**
  - IDLE: move to START when `uart_rx_en && rxd_p==1 && rxd_s==0`, i.e. on a falling edge only. A line held low never re-triggers. Clear the cycle counter.
  - START: count cycles. At `counter==HALF`, sample the line.
    - Sample is 1 (glitch): go to IDLE, no output.
    - Sample is 0: clear the counter and go to RECV.
  - RECV: count `0..CYCLES_PER_BIT`. At `CYCLES_PER_BIT`:
    - Sample the bit and shift it into the MSB of the shift register (shift right, so LSB-first).
    - Increment the bit counter and clear the cycle counter.
    - After `PAYLOAD_BITS` samples, go to STOP with the bit counter cleared.
  - STOP: sample the line at the same points as in RECV. After `STOP_BITS` samples, go to IDLE. On that transition:
    - All stop samples were 1: pulse `uart_rx_valid` and load `uart_rx_data` from the shift register in the same edge.
    - Any stop sample was 0: pulse `uart_rx_frame_err`. Also pulse `uart_rx_break` if all data and stop samples were 0. `uart_rx_data` is unchanged.
- **Enable.** Deasserting `uart_rx_en` mid-frame does not abort. The current frame completes and reports normally. `uart_rx_en` gates only the IDLE→START transition.
- **Reset mid-frame.** All state returns to reset values immediately on `resetn` low. No partial word is ever reported.
- **Mutual exclusion.** `uart_rx_valid` and `uart_rx_frame_err` are never asserted together.

## Timing
- Let `rxd_s` first read 0 at cycle t0 (2–3 clocks after the pin falls).
- Start check at t0+1+HALF.
- Data bit k is sampled at t0+1+HALF+(k+1)·P.
- Stop bit j is sampled at t0+1+HALF+(PAYLOAD_BITS+1+j)·P.
- `uart_rx_valid` / `uart_rx_frame_err` are high in exactly cycle t0+2+HALF+(PAYLOAD_BITS+STOP_BITS)·P.
- The FSM is in IDLE in the following cycle.
- **Back-to-back frames.** A start edge arriving half a bit after the last stop sample is accepted with no lost frame.
- There is no backpressure. A consumer must take `uart_rx_data` on the valid pulse or before the next one.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every sample point (start, data, stop) uses the majority of `rxd_s` over the 3 cycles ending at the sample cycle (`rxd_s`, `rxd_p`, plus one more history flop). Sample timing and latency are unchanged.
- Undefined: single sample of `rxd_s` at the sample cycle. The extra history flop is not built.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE=0, START=1, RECV=2, STOP=3), also used by the transmitter.
  - A constant function computing `CYCLES_PER_BIT` and counter width from `CLK_HZ`/`BIT_RATE`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus history taps, with a reset value of 1. It outputs `rxd_s`, `rxd_p`, and the majority-voted sample when the macro is set.
- FSM, counters, shift register and output registers live in `uart_rx`.

## Test plan
Bench parameters: `CLK_HZ=1_000_000`, `BIT_RATE=100_000` (P=11, HALF=5).
- **Good frame.** Frame 0xA5, 11-cycle bits → one `uart_rx_valid` pulse at t0+106, `uart_rx_data=0xA5`, no error.
- **Start glitch.** Line low 3 cycles then high → no output, back in IDLE. A following 0x3C frame → valid with 0x3C.
- **Framing error.** Frame 0x55 with the stop bit driven low → `uart_rx_frame_err` pulse, no valid, `uart_rx_data` keeps its previous value. Then a break of 15·P low cycles → one frame_err+break pulse and no re-trigger while low. Line high, then frame 0x01 → valid 0x01.
- **Reset mid-frame.** `resetn` low during data bit 4 → all outputs 0 at once, FSM IDLE. Next frame 0xFF → valid 0xFF.
- **Back-to-back and enable.** Frames 0x12 then 0x34 with no gap → two valid pulses with correct data. Drop `uart_rx_en` mid-0x34 → 0x34 still received, and a third frame is ignored.
- **Majority vote.** Frame 0x00 with a 1-cycle high glitch at bit 2's sample cycle:
  - Macro defined → data 0x00.
  - Macro undefined → data 0x04.
